// File: rtl/msx_slot_select_pkg.sv
// Shared MSX constants and the write-qualifier state type.
package msx_slot_select_pkg;

    localparam logic [7:0]  MSX_PRIM_PORT = 8'hA8;
    localparam logic [15:0] MSX_EXP_ADDR  = 16'hFFFF;

    typedef enum logic {
        StIdle   = 1'b0,
        StWrHold = 1'b1
    } wr_state_e;

endpackage

// File: rtl/msx_wr_once.sv
// Single-shot write qualifier: one update pulse per CPU write bus cycle.
module msx_wr_once
    import msx_slot_select_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic wr_i,
    output logic fire_o
);

    wr_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fire_o  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_i) begin
                    fire_o  = 1'b1;
                    state_d = StWrHold;
                end
            end
            StWrHold: begin
                // Wait for the strobe to drop so a held write is taken only once.
                if (!wr_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/msx_slot_select.sv
// MSX primary slot register (I/O port) plus per-slot subslot expander registers.
module msx_slot_select
    import msx_slot_select_pkg::*;
#(
    parameter logic [7:0]  PRIM_PORT = MSX_PRIM_PORT,
    parameter logic [15:0] EXP_ADDR  = MSX_EXP_ADDR,
    parameter bit          INVERT_RB = 1'b1,
    parameter bit          REG_OUT   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        cpu_mreq,
    input  logic        cpu_iorq,
    input  logic        cpu_m1,
    input  logic [3:0]  expander_en,
    input  logic [3:0]  expander_mask,
    output logic [7:0]  cpu_din,
    output logic [1:0]  active_slot,
    output logic [1:0]  subslot,
    output logic [5:0]  layout_id,
    output logic        exp_unmapped,
    output logic [7:0]  prim_reg
);

    logic [7:0] prim_q;
    logic [7:0] sub_q [4];

    logic [1:0] page;
    logic [1:0] sub_comb;
    logic [5:0] layout_comb;
    logic       bus_ok;
    logic       prim_sel, exp_sel;
    logic       prim_wr, exp_wr, prim_rd, exp_rd;
    logic       wr_fire;

    assign page        = cpu_addr[15:14];
    assign active_slot = prim_q[{page, 1'b0} +: 2];
    assign sub_comb    = expander_en[active_slot] ? sub_q[active_slot][{page, 1'b0} +: 2] : 2'b00;
    assign layout_comb = {active_slot, sub_comb, page};
    assign prim_reg    = prim_q;

    // EXP_ADDR lies in a fixed page, so active_slot here is that page's primary slot.
    assign prim_sel = cpu_iorq & ~cpu_m1 & (cpu_addr[7:0] == PRIM_PORT);
    assign exp_sel  = cpu_mreq & (cpu_addr == EXP_ADDR) & expander_en[active_slot]
                    & expander_mask[active_slot];
    assign bus_ok   = ~(cpu_mreq & cpu_iorq);

    assign prim_wr = bus_ok & prim_sel & cpu_wr;
    assign exp_wr  = bus_ok & exp_sel & cpu_wr;
    assign prim_rd = prim_sel & cpu_rd;
    assign exp_rd  = exp_sel & cpu_rd;

    msx_wr_once u_wr_once (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .req_i  (prim_wr | exp_wr),
        .wr_i   (cpu_wr),
        .fire_o (wr_fire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prim_q <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                sub_q[i] <= 8'h00;
            end
        end else begin
            if (wr_fire && prim_wr) begin
                prim_q <= cpu_dout;
            end
            if (wr_fire && exp_wr) begin
                sub_q[active_slot] <= cpu_dout;
            end
        end
    end

    // Idle value is all ones so other bus sources can be ANDed in.
    always_comb begin
        cpu_din      = 8'hFF;
        exp_unmapped = 1'b0;
        if (prim_rd) begin
            cpu_din = prim_q;
        end else if (exp_rd) begin
            cpu_din      = INVERT_RB ? ~sub_q[active_slot] : sub_q[active_slot];
            exp_unmapped = 1'b1;
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [1:0] subslot_q;
        logic [5:0] layout_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                subslot_q <= 2'b00;
                layout_q  <= 6'd0;
            end else begin
                subslot_q <= sub_comb;
                layout_q  <= layout_comb;
            end
        end

        assign subslot   = subslot_q;
        assign layout_id = layout_q;
    end else begin : g_comb_out
        assign subslot   = sub_comb;
        assign layout_id = layout_comb;
    end

endmodule

// File: tb/tb_msx_slot_select.sv
// Bench for msx_slot_select: default build and an INVERT_RB=0/REG_OUT=0 build on one bus.
module tb_msx_slot_select;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wr, cpu_rd, cpu_mreq, cpu_iorq, cpu_m1;
    logic [3:0]  expander_en, expander_mask;

    logic [7:0] din1, din2, prim1, prim2;
    logic [1:0] as1, as2, sub1, sub2;
    logic [5:0] lay1, lay2;
    logic       unm1, unm2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] prim_m;
    logic [7:0] sub_m [4];
    bit         taken_m;   // current write bus cycle has already updated a register
    logic [1:0] subr_m;    // expected registered subslot
    logic [5:0] layr_m;    // expected registered layout_id

    always #5 clk = ~clk;

    msx_slot_select dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq),
        .cpu_m1(cpu_m1), .expander_en(expander_en), .expander_mask(expander_mask),
        .cpu_din(din1), .active_slot(as1), .subslot(sub1), .layout_id(lay1),
        .exp_unmapped(unm1), .prim_reg(prim1)
    );

    msx_slot_select #(.INVERT_RB(1'b0), .REG_OUT(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq),
        .cpu_m1(cpu_m1), .expander_en(expander_en), .expander_mask(expander_mask),
        .cpu_din(din2), .active_slot(as2), .subslot(sub2), .layout_id(lay2),
        .exp_unmapped(unm2), .prim_reg(prim2)
    );

    function automatic logic [1:0] m_active(input logic [15:0] a);
        int p = int'(a[15:14]);
        return prim_m[2*p +: 2];
    endfunction

    function automatic logic [1:0] m_sub(input logic [15:0] a);
        int p = int'(a[15:14]);
        logic [1:0] s = m_active(a);
        logic [7:0] r = sub_m[s];
        return expander_en[s] ? r[2*p +: 2] : 2'b00;
    endfunction

    function automatic bit m_exp_rd();
        logic [1:0] s = prim_m[7:6];
        return cpu_mreq && cpu_rd && cpu_addr == 16'hFFFF && expander_en[s] && expander_mask[s];
    endfunction

    function automatic logic [7:0] m_din(input bit inv);
        logic [7:0] v = sub_m[prim_m[7:6]];
        if (cpu_iorq && !cpu_m1 && cpu_rd && cpu_addr[7:0] == 8'hA8) return prim_m;
        if (m_exp_rd()) return inv ? ~v : v;
        return 8'hFF;
    endfunction

    task automatic model_reset();
        prim_m  = 8'h00;
        for (int i = 0; i < 4; i++) sub_m[i] = 8'h00;
        taken_m = 1'b0;
        subr_m  = 2'b00;
        layr_m  = 6'd0;
    endtask

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic cycle();
        bit both, pw, ew;
        logic [1:0] s3;
        logic [7:0] d;
        logic [5:0] nl;
        logic [1:0] ns;
        both = cpu_mreq && cpu_iorq;
        s3   = prim_m[7:6];
        d    = cpu_dout;
        pw   = !both && cpu_iorq && !cpu_m1 && cpu_wr && cpu_addr[7:0] == 8'hA8;
        ew   = !both && cpu_mreq && cpu_wr && cpu_addr == 16'hFFFF
               && expander_en[s3] && expander_mask[s3];
        nl   = {m_active(cpu_addr), m_sub(cpu_addr), cpu_addr[15:14]};
        ns   = m_sub(cpu_addr);
        @(posedge clk);
        #1;
        if (!taken_m && (pw || ew)) begin
            if (pw) prim_m = d;
            if (ew) sub_m[s3] = d;
            taken_m = 1'b1;
        end else if (taken_m && !cpu_wr) begin
            taken_m = 1'b0;
        end
        subr_m = ns;
        layr_m = nl;
    endtask

    task automatic bus(input logic [15:0] a, input logic mreq, input logic iorq,
                       input logic wr, input logic rd, input logic [7:0] d);
        cpu_addr = a; cpu_mreq = mreq; cpu_iorq = iorq; cpu_m1 = 1'b0;
        cpu_wr = wr; cpu_rd = rd; cpu_dout = d;
    endtask

    task automatic io_write(input logic [7:0] d);
        bus(16'h00A8, 1'b0, 1'b1, 1'b1, 1'b0, d); cycle();
        bus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); cycle();
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        bus(a, 1'b1, 1'b0, 1'b1, 1'b0, d); cycle();
        bus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus(16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expander_en = 4'hF; expander_mask = 4'hF;
        model_reset();
        #12;
        checks++; if (prim1 !== 8'h00) begin errors++; $display("FAIL reset_prim got %h exp 00", prim1); end
        checks++; if (lay1 !== 6'd0) begin errors++; $display("FAIL reset_layout got %h exp 00", lay1); end
        checks++; if (sub1 !== 2'b00) begin errors++; $display("FAIL reset_subslot got %b exp 00", sub1); end
        checks++; if (din1 !== 8'hFF || unm1 !== 1'b0) begin
            errors++; $display("FAIL reset_din got %h/%b exp FF/0", din1, unm1);
        end
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_primary();
        io_write(8'hE4);
        checks++; if (prim1 !== 8'hE4) begin errors++; $display("FAIL prim_write got %h exp E4", prim1); end
        bus(16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); #1;
        checks++; if (as1 !== 2'd1) begin errors++; $display("FAIL slot_4000 got %0d exp 1", as1); end
        bus(16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); #1;
        checks++; if (as1 !== 2'd3) begin errors++; $display("FAIL slot_C000 got %0d exp 3", as1); end
        bus(16'h00A8, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00); #1;
        checks++; if (din1 !== 8'hE4) begin errors++; $display("FAIL prim_read got %h exp E4", din1); end
        // Simultaneous MREQ and IORQ must not write.
        bus(16'h00A8, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A); cycle();
        bus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); cycle();
        checks++; if (prim1 !== 8'hE4) begin errors++; $display("FAIL both_strobes got %h exp E4", prim1); end
    endtask

    task automatic test_expander();
        io_write(8'hC0);
        expander_en = 4'b1000; expander_mask = 4'b1111;
        mem_write(16'hFFFF, 8'h1B);
        bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); #1;
        checks++; if (din1 !== 8'hE4 || unm1 !== 1'b1) begin
            errors++; $display("FAIL exp_read_inv got %h/%b exp E4/1", din1, unm1);
        end
        checks++; if (din2 !== 8'h1B || unm2 !== 1'b1) begin
            errors++; $display("FAIL exp_read_true got %h/%b exp 1B/1", din2, unm2);
        end
        // Page 1 of slot 3 selects subslot bits [3:2] = 2 only if page 1 maps to slot 3.
        io_write(8'hCC);
        bus(16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); #1;
        checks++; if (sub2 !== 2'b10) begin errors++; $display("FAIL subslot_p1 got %b exp 10", sub2); end
        io_write(8'hC0);
    endtask

    task automatic test_wr_hold();
        bus(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11); cycle();
        cpu_dout = 8'h22;
        for (int i = 0; i < 4; i++) cycle();
        bus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); cycle();
        bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); #1;
        checks++; if (din2 !== 8'h11) begin errors++; $display("FAIL held_write got %h exp 11", din2); end
        mem_write(16'hFFFF, 8'h33);
        bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); #1;
        checks++; if (din2 !== 8'h33) begin errors++; $display("FAIL after_hold got %h exp 33", din2); end
    endtask

    task automatic test_unexpanded();
        expander_en = 4'b0111;
        mem_write(16'hFFFF, 8'h77);
        bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); #1;
        checks++; if (din1 !== 8'hFF || unm1 !== 1'b0 || sub2 !== 2'b00) begin
            errors++; $display("FAIL unexpanded got %h/%b/%b exp FF/0/00", din1, unm1, sub2);
        end
        expander_en = 4'b1000; expander_mask = 4'b0111;
        mem_write(16'hFFFF, 8'h88);
        bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); #1;
        checks++; if (din1 !== 8'hFF || unm1 !== 1'b0) begin
            errors++; $display("FAIL masked got %h/%b exp FF/0", din1, unm1);
        end
        expander_mask = 4'b1111; #1;
        checks++; if (din2 !== 8'h33) begin errors++; $display("FAIL sub_kept got %h exp 33", din2); end
    endtask

    task automatic test_reset_in_hold();
        bus(16'h00A8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55); cycle();
        #2 reset_n = 1'b0;
        model_reset();
        cpu_dout = 8'h66;
        #1;
        checks++; if (prim1 !== 8'h00 || lay1 !== 6'd0) begin
            errors++; $display("FAIL async_reset got %h/%h exp 00/00", prim1, lay1);
        end
        reset_n = 1'b1;
        cycle();
        checks++; if (prim1 !== 8'h66) begin errors++; $display("FAIL post_reset_wr got %h exp 66", prim1); end
        bus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); cycle();
    endtask

    task automatic test_reg_latency();
        expander_en = 4'b0000;
        io_write(8'h30);
        bus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); cycle();
        cpu_addr = 16'h8000; #1;
        checks++; if (lay2 !== 6'b11_00_10) begin errors++; $display("FAIL comb_layout got %b exp 110010", lay2); end
        checks++; if (lay1 !== 6'b00_00_00) begin errors++; $display("FAIL reg_layout_early got %b exp 000000", lay1); end
        cycle();
        checks++; if (lay1 !== 6'b11_00_10) begin errors++; $display("FAIL reg_layout_late got %b exp 110010", lay1); end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 3);
            if (r == 0) cpu_addr = 16'hFFFF;
            else if (r == 1) cpu_addr = {8'($urandom), 8'hA8};
            else cpu_addr = 16'($urandom);
            cpu_mreq = ($urandom_range(0, 1) == 1);
            cpu_iorq = ($urandom_range(0, 1) == 1);
            cpu_m1   = ($urandom_range(0, 3) == 0);
            cpu_wr   = ($urandom_range(0, 1) == 1);
            cpu_rd   = !cpu_wr && ($urandom_range(0, 1) == 1);
            cpu_dout = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                expander_en = 4'($urandom); expander_mask = 4'($urandom);
            end
            #1;
            checks++; if (prim1 !== prim_m || prim2 !== prim_m) begin
                errors++; $display("FAIL rnd_prim got %h/%h exp %h", prim1, prim2, prim_m);
            end
            checks++; if (as1 !== m_active(cpu_addr)) begin
                errors++; $display("FAIL rnd_slot got %0d exp %0d", as1, m_active(cpu_addr));
            end
            checks++; if (din1 !== m_din(1'b1) || din2 !== m_din(1'b0)) begin
                errors++; $display("FAIL rnd_din got %h/%h exp %h/%h", din1, din2, m_din(1'b1), m_din(1'b0));
            end
            checks++; if (unm1 !== m_exp_rd() || unm2 !== m_exp_rd()) begin
                errors++; $display("FAIL rnd_unmapped got %b/%b exp %b", unm1, unm2, m_exp_rd());
            end
            checks++; if (sub2 !== m_sub(cpu_addr) ||
                          lay2 !== {m_active(cpu_addr), m_sub(cpu_addr), cpu_addr[15:14]}) begin
                errors++; $display("FAIL rnd_comb_out got %b/%b exp %b", sub2, lay2, m_sub(cpu_addr));
            end
            checks++; if (sub1 !== subr_m || lay1 !== layr_m) begin
                errors++; $display("FAIL rnd_reg_out got %b/%b exp %b/%b", sub1, lay1, subr_m, layr_m);
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_expander();
        test_wr_hold();
        test_unexpanded();
        test_reset_in_hold();
        test_reg_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msx_slot_select.md
MSX_SLOT_SELECT -- requirements
Module: msx_slot_select

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide parameter PRIM_PORT, default 8'hA8: I/O port of the primary slot register.
REQ-003 The block SHALL provide parameter EXP_ADDR, default 16'hFFFF: memory address of the subslot (expander) register.
REQ-004 The block SHALL provide parameter INVERT_RB, default 1: 1 = subslot readback inverted, 0 = readback true.
REQ-005 The block SHALL provide parameter REG_OUT, default 1: 1 = layout_id/subslot registered, 0 = combinational.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
  - clk  in  1  system clock
  - reset_n  in  1  asynchronous reset, active low
  - cpu_addr  in  16  CPU address
  - cpu_dout  in  8  CPU write data
  - cpu_wr, cpu_rd, cpu_mreq, cpu_iorq, cpu_m1  in  1 each  CPU strobes, active high
  - expander_en  in  4  per-primary-slot expander present
  - expander_mask  in  4  per-slot external gate for the expander register; 0 = register hidden
  - cpu_din  out  8  read data; 8'hFF when not driving
  - active_slot  out  2  primary slot of the page addressed by cpu_addr[15:14]; combinational
  - subslot  out  2  subslot of the addressed page
  - layout_id  out  6  {active_slot, subslot, page}
  - exp_unmapped  out  1  suppresses memory while the expander register is read
  - prim_reg  out  8  primary register contents, for debug

Function
REQ-007 active_slot SHALL equal prim_reg[2*page +: 2], where page = cpu_addr[15:14].
REQ-008 subslot SHALL equal sub_reg[active_slot][2*page +: 2] when expander_en[active_slot] = 1, and 2'b00 otherwise.
REQ-009 With REG_OUT = 1, subslot and layout_id SHALL be registered, one clk of latency after cpu_addr or either register changes; with REG_OUT = 0 they SHALL be combinational.
REQ-010 A primary write SHALL be cpu_iorq & ~cpu_m1 & cpu_wr & cpu_addr[7:0] == PRIM_PORT.
REQ-011 An expander write SHALL be cpu_mreq & cpu_wr & cpu_addr == EXP_ADDR & expander_en[active_slot] & expander_mask[active_slot].
REQ-012 The write FSM SHALL have states IDLE and WR_HOLD.
REQ-013 In IDLE, a qualifying write SHALL update its register on that clk edge, then the FSM SHALL go to WR_HOLD.
REQ-014 In WR_HOLD, no register SHALL update; the FSM SHALL return to IDLE when cpu_wr = 0, so each bus cycle causes exactly one update.
REQ-015 The expander write SHALL target sub_reg[active_slot], with active_slot taken from the page-3 field of prim_reg before the write.
REQ-016 If cpu_mreq and cpu_iorq are both asserted, no write SHALL occur and the FSM SHALL remain in IDLE.
REQ-017 A write to EXP_ADDR in a non-expanded or masked slot SHALL leave every register unchanged and keep exp_unmapped = 0; the write passes through to memory.
REQ-018 A primary read (cpu_iorq & ~cpu_m1 & cpu_rd & port match) SHALL drive cpu_din = prim_reg combinationally.
REQ-019 An expander read (REQ-011 conditions with cpu_rd in place of cpu_wr) SHALL drive cpu_din = ~sub_reg[active_slot] when INVERT_RB = 1, otherwise sub_reg[active_slot], and SHALL assert exp_unmapped, both combinationally.
REQ-020 In all other cases cpu_din SHALL be 8'hFF and exp_unmapped SHALL be 0.
REQ-021 cpu_din SHALL be AND-combinable with other sources on the bus.

Reset
REQ-022 While reset_n = 0: prim_reg = 8'h00, all sub_reg = 8'h00, FSM = IDLE, registered subslot = 2'b00, registered layout_id = 6'd0.
REQ-023 Reset SHALL act asynchronously on assertion, including in WR_HOLD, and SHALL abort any write in progress.
REQ-024 After reset deasserts, the first qualifying strobe SHALL be accepted even if cpu_wr is already high.

Structure
REQ-025 The shared MSX package SHALL hold the default port and address constants and a typedef for the FSM state enum.
REQ-026 sub_reg SHALL be an unpacked array of four 8-bit registers inside this block.
REQ-027 There SHALL be one sub-module, msx_wr_once, implementing the IDLE/WR_HOLD single-shot strobe qualifier; it is instantiated once and shared by both registers.

Verification
REQ-028 Write 8'hE4 to port A8 via I/O -> prim_reg = 8'hE4; cpu_addr 16'h4000 -> active_slot = 1; cpu_addr 16'hC000 -> active_slot = 3.
REQ-029 With prim_reg = 8'hC0, expander_en = 4'b1000, mask all 1: write 8'h1B to FFFF -> sub_reg[3] = 8'h1B; read FFFF -> cpu_din = 8'hE4 and exp_unmapped = 1; with INVERT_RB = 0 the read returns 8'h1B.
REQ-030 Hold cpu_wr high for 5 clk across two data values -> only the first value is stored; the FSM stays in WR_HOLD until cpu_wr falls.
REQ-031 Write and read FFFF with expander_en[3] = 0 -> sub_reg unchanged, cpu_din = 8'hFF, exp_unmapped = 0, subslot = 0.
REQ-032 Assert reset_n = 0 while in WR_HOLD -> all registers clear immediately; after release, a pending write is accepted.
REQ-033 With REG_OUT = 1, change cpu_addr from 16'h0000 to 16'h8000 -> layout_id updates exactly one clk later; with REG_OUT = 0 it updates in the same cycle.
